// File: rtl/fifo_defines_pkg.sv
// fifo_defines_pkg: shared widths, FSM states and waveform selects for the function generator
package fifo_defines_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int INT_BITS = 8;
  localparam int LUT_ADDR = 6;
  localparam int PHASE_WIDTH = 16;
  localparam int DATA_WIDTH_OUT = DATA_WIDTH + INT_BITS;
  typedef enum logic [1:0] {IDLE, CONFI, GEN} gen_state_t;
  typedef enum logic [1:0] {SIN, COS, TRI, SQU} wave_sel_t;
endpackage

// File: rtl/funct_generator_lut.sv
// funct_generator_lut: synchronous-read sine ROM built from a quarter-wave table and its symmetry
module funct_generator_lut #(
  parameter int DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
  parameter int LUT_ADDR = fifo_defines_pkg::LUT_ADDR
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [LUT_ADDR-1:0]          addr,
  output logic signed [DATA_WIDTH-1:0] q
);
  localparam int QA = LUT_ADDR - 2;
  localparam logic [15:0] QW [17] = '{16'd0, 16'd3212, 16'd6393, 16'd9512, 16'd12539, 16'd15446,
    16'd18204, 16'd20787, 16'd23170, 16'd25329, 16'd27245, 16'd28898, 16'd30273, 16'd31356,
    16'd32137, 16'd32609, 16'd32767};
  logic [QA:0] qi;
  logic [15:0] m;
  always_comb begin
    qi = addr[QA] ? (QA+1)'(2 ** QA) - {1'b0, addr[QA-1:0]} : {1'b0, addr[QA-1:0]};
    m = QW[qi];
  end
  always_ff @(posedge clk)
    if (en) q <= addr[LUT_ADDR-1] ? DATA_WIDTH'(-m) : DATA_WIDTH'(m);
endmodule

// File: rtl/funct_generator_mc.sv
// funct_generator_mc: round-robin multi-channel waveform generator with amplitude scaling and FIFO backpressure
module funct_generator_mc #(
  parameter int N_CH = 2,
  parameter int DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
  parameter int INT_BITS = fifo_defines_pkg::INT_BITS,
  parameter int LUT_ADDR = fifo_defines_pkg::LUT_ADDR,
  parameter int PHASE_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en_low_i,
  input  logic                                  enh_conf_i,
  input  logic                                  cfg_we_i,
  input  logic [$clog2(N_CH)-1:0]               cfg_ch_i,
  input  logic signed [INT_BITS-1:0]            cfg_amp_i,
  input  logic [1:0]                            cfg_sel_i,
  input  logic [PHASE_WIDTH-1:0]                cfg_step_i,
  input  logic                                  full_i,
  output logic                                  wr_en_o,
  output logic signed [DATA_WIDTH+INT_BITS-1:0] data_o,
  output logic [$clog2(N_CH)-1:0]               ch_o,
  output logic [1:0]                            state_o
);
  import fifo_defines_pkg::*;
  localparam int CW = $clog2(N_CH);
  localparam int DO = DATA_WIDTH + INT_BITS;
  localparam logic [DATA_WIDTH-1:0] MAXP = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  gen_state_t state, nxt;
  logic signed [INT_BITS-1:0] amp [N_CH];
  wave_sel_t sel [N_CH];
  logic [PHASE_WIDTH-1:0] step [N_CH];
  logic [PHASE_WIDTH-1:0] phase [N_CH];
  logic [CW-1:0] ptr, s1_ch, s2_ch;
  logic s1_valid, s2_valid, adv, run;
  wave_sel_t s1_sel;
  logic signed [INT_BITS-1:0] s1_amp;
  logic signed [DATA_WIDTH-1:0] s1_alt, lut_q, wave, tw, sw;
  logic signed [DO-1:0] s2_data;
  logic [DATA_WIDTH-1:0] u;
  logic [LUT_ADDR-1:0] a, lut_addr;
  assign adv = !full_i;
  assign run = state == GEN && nxt == GEN;
  assign wr_en_o = s2_valid & adv;
  assign data_o = s2_data;
  assign ch_o = s2_ch;
  assign state_o = state;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = enh_conf_i ? CONFI : (en_low_i ? IDLE : GEN);
      CONFI:   nxt = enh_conf_i ? CONFI : IDLE;
      GEN:     nxt = (enh_conf_i || en_low_i) ? IDLE : GEN;
      default: nxt = IDLE;
    endcase
  end
  // triangle/square are computed at issue; sin/cos come from the ROM one cycle later
  always_comb begin
    u = phase[ptr][PHASE_WIDTH-1 -: DATA_WIDTH];
    a = phase[ptr][PHASE_WIDTH-1 -: LUT_ADDR];
    tw = u[DATA_WIDTH-1] ? MAXP - {u[DATA_WIDTH-2:0], 1'b0} : {u[DATA_WIDTH-2:0], 1'b0} - MINV;
    sw = u[DATA_WIDTH-1] ? MINV + DATA_WIDTH'(1) : MAXP;
    lut_addr = sel[ptr] == COS ? a + LUT_ADDR'(2 ** (LUT_ADDR - 2)) : a;
    wave = (s1_sel == SIN || s1_sel == COS) ? lut_q : s1_alt;
  end
  funct_generator_lut #(.DATA_WIDTH(DATA_WIDTH), .LUT_ADDR(LUT_ADDR)) u_lut (
    .clk(clk), .en(adv && run), .addr(lut_addr), .q(lut_q)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < N_CH; i++) begin
        amp[i] <= '0;
        sel[i] <= SIN;
        step[i] <= '0;
      end
    end else begin
      state <= nxt;
      if (state == CONFI && cfg_we_i && int'(cfg_ch_i) < N_CH) begin
        amp[cfg_ch_i] <= cfg_amp_i;
        sel[cfg_ch_i] <= wave_sel_t'(cfg_sel_i);
        step[cfg_ch_i] <= cfg_step_i;
      end
    end
  always_ff @(posedge clk)
    if (rst || !run) begin
      ptr <= '0;
      for (int i = 0; i < N_CH; i++) phase[i] <= '0;
    end else if (adv) begin
      phase[ptr] <= phase[ptr] + step[ptr];
      ptr <= ptr == CW'(N_CH - 1) ? '0 : ptr + CW'(1);
    end
  always_ff @(posedge clk)
    if (rst || nxt != GEN) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= state == GEN;
      s2_valid <= s1_valid;
    end
  always_ff @(posedge clk)
    if (rst) begin
      s1_ch <= '0;
      s1_sel <= SIN;
      s1_amp <= '0;
      s1_alt <= '0;
      s2_ch <= '0;
      s2_data <= '0;
    end else if (adv) begin
      if (run) begin
        s1_ch <= ptr;
        s1_sel <= sel[ptr];
        s1_amp <= amp[ptr];
        s1_alt <= sel[ptr] == TRI ? tw : sw;
      end
      if (s1_valid) begin
        s2_ch <= s1_ch;
        s2_data <= DO'(wave) * DO'(s1_amp);
      end
    end
endmodule

// File: tb/tb_funct_generator_mc.sv
// tb_funct_generator_mc: directed and random stimulus checked against a queue-based behavioural model
module tb_funct_generator_mc;
  localparam int N_CH = 2;
  logic clk = 0, rst = 1, en_low_i = 1, enh_conf_i = 0, cfg_we_i = 0, full_i = 0;
  logic [0:0] cfg_ch_i = '0;
  logic [7:0] cfg_amp_i = '0;
  logic [1:0] cfg_sel_i = '0;
  logic [15:0] cfg_step_i = '0;
  logic wr_en_o;
  logic [23:0] data_o;
  logic [0:0] ch_o;
  logic [1:0] state_o;
  int errors = 0, checks = 0;
  typedef struct {int ch; int data; int age;} item_t;
  typedef struct {int ch; int data; int dt;} wr_t;
  item_t pq[$];
  wr_t wlog[$];
  int m_state = 0, m_ptr = 0, cyc = 0, gen_t0 = 0;
  int m_amp[N_CH], m_sel[N_CH], m_step[N_CH], m_phase[N_CH];
  always #5 clk = ~clk;
  funct_generator_mc #(.N_CH(2), .DATA_WIDTH(16), .INT_BITS(8), .LUT_ADDR(6), .PHASE_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en_low_i(en_low_i), .enh_conf_i(enh_conf_i), .cfg_we_i(cfg_we_i),
    .cfg_ch_i(cfg_ch_i), .cfg_amp_i(cfg_amp_i), .cfg_sel_i(cfg_sel_i), .cfg_step_i(cfg_step_i),
    .full_i(full_i), .wr_en_o(wr_en_o), .data_o(data_o), .ch_o(ch_o), .state_o(state_o)
  );
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic int lut(int k);
    real r;
    r = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 64.0);
    return r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction
  function automatic int wave(int s, int ph);
    int a;
    a = ph >> 10;
    case (s)
      0: return lut(a);
      1: return lut((a + 16) % 64);
      2: return ph < 32768 ? 2 * ph - 32768 : 32767 - 2 * (ph - 32768);
      default: return ph < 32768 ? 32767 : -32767;
    endcase
  endfunction
  function automatic int next_state(int s, logic enh, logic enl);
    case (s)
      0: return enh ? 1 : (enl ? 0 : 2);
      1: return enh ? 1 : 0;
      2: return (enh || enl) ? 0 : 2;
      default: return 0;
    endcase
  endfunction
  function automatic int find(int ch, int n);
    int c;
    c = 0;
    foreach (wlog[i]) if (wlog[i].ch == ch) begin
      if (c == n) return wlog[i].data;
      c++;
    end
    return -99999999;
  endfunction
  always @(negedge clk) begin
    int nxt;
    logic adv, ew;
    cyc++;
    if (rst) begin
      m_state = 0;
      m_ptr = 0;
      pq.delete();
      for (int i = 0; i < N_CH; i++) begin
        m_amp[i] = 0; m_sel[i] = 0; m_step[i] = 0; m_phase[i] = 0;
      end
    end else begin
      adv = !full_i;
      ew = pq.size() > 0 && pq[0].age >= 2 && adv;
      chk("wr_en", int'(wr_en_o), int'(ew));
      chk("state", int'(state_o), m_state);
      if (pq.size() > 0 && pq[0].age >= 2) begin
        chk("data", int'($signed(data_o)), pq[0].data);
        chk("ch", int'(ch_o), pq[0].ch);
      end
      if (wr_en_o) wlog.push_back('{int'(ch_o), int'($signed(data_o)), cyc - gen_t0});
      nxt = next_state(m_state, enh_conf_i, en_low_i);
      if (ew) void'(pq.pop_front());
      if (adv) foreach (pq[i]) pq[i].age++;
      if (m_state == 2 && nxt == 2 && adv) begin
        pq.push_back('{m_ptr, wave(m_sel[m_ptr], m_phase[m_ptr]) * m_amp[m_ptr], 1});
        m_phase[m_ptr] = (m_phase[m_ptr] + m_step[m_ptr]) % 65536;
        m_ptr = (m_ptr + 1) % N_CH;
      end
      if (nxt != 2) begin
        pq.delete();
        m_ptr = 0;
        for (int i = 0; i < N_CH; i++) m_phase[i] = 0;
      end
      if (m_state == 1 && cfg_we_i) begin
        m_amp[cfg_ch_i] = int'($signed(cfg_amp_i));
        m_sel[cfg_ch_i] = int'(cfg_sel_i);
        m_step[cfg_ch_i] = int'(cfg_step_i);
      end
      if (nxt == 2 && m_state != 2) gen_t0 = cyc + 1;
      m_state = nxt;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(int ch, int amp, int s, int st);
    cfg_we_i = 1;
    cfg_ch_i = 1'(ch);
    cfg_amp_i = 8'(amp);
    cfg_sel_i = 2'(s);
    cfg_step_i = 16'(st);
    tick();
    cfg_we_i = 0;
  endtask
  task automatic to_conf();
    en_low_i = 1;
    enh_conf_i = 0;
    tick();
    enh_conf_i = 1;
    tick();
  endtask
  task automatic start_gen();
    enh_conf_i = 0;
    wlog.delete();
    en_low_i = 0;
    tick();
  endtask
  initial begin
    int exp_ch[4] = '{0, 1, 0, 1};
    int exp_sq[4] = '{32767, 0, 32767, -25078};
    int exp_tri[6] = '{-32768, 0, 32767, -1, -32768, 0};
    repeat (2) tick();
    @(negedge clk);
    chk("rst_wr_en", int'(wr_en_o), 0);
    chk("rst_data", int'($signed(data_o)), 0);
    chk("rst_ch", int'(ch_o), 0);
    chk("rst_state", int'(state_o), 0);
    tick();
    rst = 0;
    to_conf();
    cfg(0, 1, 3, 'h0400);
    enh_conf_i = 0;
    cfg(1, -2, 0, 'h1000);
    start_gen();
    repeat (8) tick();
    chk("sq_first_latency", wlog.size() > 0 ? wlog[0].dt : -1, 2);
    for (int i = 0; i < 4; i++) begin
      chk("sq_sin_ch", wlog.size() > i ? wlog[i].ch : -1, exp_ch[i]);
      chk("sq_sin_data", wlog.size() > i ? wlog[i].data : -99999999, exp_sq[i]);
    end
    to_conf();
    cfg(0, 1, 2, 'h4000);
    start_gen();
    repeat (5) tick();
    full_i = 1;
    repeat (3) tick();
    full_i = 0;
    cfg(0, 5, 3, 'h1234);
    cfg(0, 5, 3, 'h1234);
    repeat (12) tick();
    for (int i = 0; i < 6; i++) chk("tri_bp_ch0", find(0, i), exp_tri[i]);
    en_low_i = 1;
    tick();
    @(negedge clk);
    chk("exit_state", int'(state_o), 0);
    chk("exit_wr_en", int'(wr_en_o), 0);
    tick();
    start_gen();
    repeat (8) tick();
    chk("reentry_ch0", find(0, 0), -32768);
    chk("reentry_latency", wlog.size() > 0 ? wlog[0].dt : -1, 2);
    to_conf();
    cfg(1, -128, 1, 'h0100);
    start_gen();
    repeat (8) tick();
    chk("cos_fullscale", find(1, 0), -4194176);
    repeat (1500) begin
      full_i = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 29) == 0) en_low_i = !en_low_i;
      enh_conf_i = enh_conf_i ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 59) == 0);
      cfg_we_i = $urandom_range(0, 3) == 0;
      cfg_ch_i = 1'($urandom_range(0, 1));
      cfg_amp_i = 8'($urandom);
      cfg_sel_i = 2'($urandom);
      cfg_step_i = 16'($urandom);
      tick();
    end
    cfg_we_i = 0;
    full_i = 0;
    enh_conf_i = 0;
    en_low_i = 0;
    repeat (4) tick();
    rst = 1;
    tick();
    @(negedge clk);
    chk("rst_in_gen_state", int'(state_o), 0);
    chk("rst_in_gen_wr_en", int'(wr_en_o), 0);
    tick();
    rst = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
